// File: rtl/behavioral_y_model.sv
// -----------------------------------------------------------------------------
// behavioral_y_model
//
// Evaluates the fixed four-input Boolean function
//     y = (~a & b) | (c & ~d)
// in three independent ways (sum-of-products, product-of-sums and a 16-entry
// truth-table lookup). The three results are cross-checked on every clock
// edge, and any disagreement sets a sticky error flag.
//
// Parameters:
//   REG_OUT  1: y is registered; 0: y follows y_comb and ignores rst.
//   TT_INIT  truth table; bit i holds y for minterm i = {a,b,c,d}.
//            Only 16'h44F4 is correct. Any other value drives mismatch
//            once a differing minterm is applied.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   a,b,c,d   operands; a is the MSB of the minterm index, d is the LSB
//   y         function result (registered when REG_OUT=1)
//   y_comb    combinational sum-of-products result
//   minterm   registered one-hot decode of {a,b,c,d}
//   mismatch  sticky flag: the three implementations disagreed
// -----------------------------------------------------------------------------
module behavioral_y_model #(
  parameter bit          REG_OUT = 1'b1,
  parameter logic [15:0] TT_INIT = 16'h44F4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic        y,
  output logic        y_comb,
  output logic [15:0] minterm,
  output logic        mismatch
);

  logic [3:0]  idx;
  logic        y_sop;
  logic        y_pos;
  logic        y_tt;
  logic        disagree;
  logic [15:0] one_hot;
  logic [15:0] minterm_q;
  logic        mismatch_q;

  assign idx = {a, b, c, d};

  // The three forms are kept as separate expressions so that the cross-check
  // compares genuinely different logic.
  assign y_sop = (~a & b) | (c & ~d);
  assign y_pos = (~a | ~d) & (b | c) & (~a | c) & (b | ~d);
  assign y_tt  = TT_INIT[idx];

  assign disagree = (y_sop ^ y_pos) | (y_sop ^ y_tt);
  assign one_hot  = 16'h0001 << idx;

  assign y_comb = y_sop;

  always_ff @(posedge clk) begin
    if (rst) begin
      minterm_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      minterm_q  <= one_hot;
      mismatch_q <= mismatch_q | disagree;
    end
  end

  assign minterm  = minterm_q;
  assign mismatch = mismatch_q;

  // With REG_OUT=0 the output bypasses the register entirely, so reset has
  // no influence on y in that configuration.
  generate
    if (REG_OUT) begin : g_y_reg
      logic y_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          y_q <= 1'b0;
        end else begin
          y_q <= y_sop;
        end
      end

      assign y = y_q;
    end else begin : g_y_comb
      assign y = y_sop;
    end
  endgenerate

endmodule

// File: tb/tb_behavioral_y_model.sv
module tb_behavioral_y_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

  // default instance
  logic        y_m, yc_m, mm_m;
  logic [15:0] mt_m;
  // corrupted truth table instance
  logic        y_t, yc_t, mm_t;
  logic [15:0] mt_t;
  // unregistered-output instance
  logic        y_c, yc_c, mm_c;
  logic [15:0] mt_c;

  behavioral_y_model dut_main (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .y(y_m), .y_comb(yc_m), .minterm(mt_m), .mismatch(mm_m)
  );

  behavioral_y_model #(.TT_INIT(16'h44F5)) dut_tt (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .y(y_t), .y_comb(yc_t), .minterm(mt_t), .mismatch(mm_t)
  );

  behavioral_y_model #(.REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .y(y_c), .y_comb(yc_c), .minterm(mt_c), .mismatch(mm_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        y;
    logic [15:0] minterm;
    logic        mm_tt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic mm_tt_model = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: y is 1 exactly for minterms 2,4,5,6,7,10,14.
  function automatic logic ref_y(input logic [3:0] v);
    case (v)
      4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd14: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // queue the registered expectation, then compare after the rising edge.
  task automatic do_cycle(input logic [3:0] v, input logic r);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    {a, b, c, d} = v;
    rst = r;
    #1;
    check_val("y_comb", {15'd0, yc_m}, {15'd0, ref_y(v)});
    check_val("y_unreg", {15'd0, y_c}, {15'd0, ref_y(v)});
    e.y       = r ? 1'b0 : ref_y(v);
    e.minterm = r ? 16'h0000 : (16'h0001 << v);
    mm_tt_model = r ? 1'b0 : (mm_tt_model | (v == 4'd0));
    e.mm_tt   = mm_tt_model;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 16'd1, 16'd0);
    end else begin
      got_e = sb.pop_front();
      check_val("y_reg", {15'd0, y_m}, {15'd0, got_e.y});
      check_val("minterm", mt_m, got_e.minterm);
      check_val("mismatch_main", {15'd0, mm_m}, 16'd0);
      check_val("mismatch_tt", {15'd0, mm_t}, {15'd0, got_e.mm_tt});
      check_val("minterm_unreg_inst", mt_c, got_e.minterm);
      check_val("y_unreg_post", {15'd0, y_c}, {15'd0, ref_y(v)});
    end
  endtask

  logic [3:0] dir_vec [6];

  initial begin
    dir_vec[0] = 4'b0000; dir_vec[1] = 4'b0010; dir_vec[2] = 4'b1101;
    dir_vec[3] = 4'b1011; dir_vec[4] = 4'b0110; dir_vec[5] = 4'b1110;

    // reset
    do_cycle(4'b0110, 1'b1);
    do_cycle(4'b0010, 1'b1);

    // full index sweep
    for (int i = 0; i < 16; i++) do_cycle(4'(i), 1'b0);

    // directed vectors, held 10 cycles each
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 10; k++) do_cycle(dir_vec[i], 1'b0);

    // reset mid-operation, input held at 0110
    do_cycle(4'b0110, 1'b0);
    do_cycle(4'b0110, 1'b0);
    do_cycle(4'b0110, 1'b1);
    do_cycle(4'b0110, 1'b0);
    do_cycle(4'b0110, 1'b0);

    // reset coinciding with an input change
    do_cycle(4'b0010, 1'b1);
    do_cycle(4'b0100, 1'b0);

    // back-to-back alternation
    for (int i = 0; i < 20; i++) do_cycle((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);

    // random tail
    for (int i = 0; i < 30; i++) do_cycle(4'($urandom_range(15, 0)), ($urandom_range(9, 0) == 0));

    check_val("sb_drain", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/behavioral_y_model.md
# behavioral_y_model

Evaluates the fixed four-input Boolean function y = (~a & b) | (c & ~d) and presents it both combinationally and as a registered output. The function is computed three ways: sum-of-products, product-of-sums, and a 16-entry truth-table lookup. The three results are continuously cross-checked, and any disagreement raises a sticky error flag. This is the leaf logic block of the Y-expression experiment and is driven directly from switch or stimulus inputs.

## Interface
- REG_OUT, default 1: 1 = `y` is registered; 0 = `y` equals `y_comb`, and reset has no effect on `y`.
- TT_INIT, default 16'h44F4: truth-table constant, where bit i is y for minterm i. Only the default value is legal; any other value must make `mismatch` assert.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; synchronous and active-high (single clock domain).
- a  input  1  operand, MSB of the minterm index.
- b  input  1  operand.
- c  input  1  operand.
- d  input  1  operand, LSB of the minterm index.
- y  output  1  function result (registered when REG_OUT=1).
- y_comb  output  1  combinational function result (sum-of-products form).
- minterm  output  16  registered one-hot decode of index {a,b,c,d}.
- mismatch  output  1  sticky error flag: implementations disagreed.

## Operation
- Index: idx = {a,b,c,d}, range 0..15.
- Sum-of-products form: y_sop = (~a & b) | (c & ~d).
- Product-of-sums form: y_pos = (~a | ~d) & (b | c) & (~a | c) & (b | ~d).
  - This is algebraically equal to y_sop and must be written as a separate expression.
- Truth-table form: y_tt = TT_INIT[idx].
  - y is 1 exactly for minterms {2, 4, 5, 6, 7, 10, 14}.
- `y_comb` = y_sop, purely combinational, with no dependence on clk or rst.
- Registered path, every rising clk edge with rst=0:
  - y <= y_sop
  - minterm <= (16'h1 << idx)
  - mismatch <= mismatch | (y_sop ^ y_pos) | (y_sop ^ y_tt)
- Reset, rising clk edge with rst=1:
  - y <= 0, minterm <= 16'h0000, mismatch <= 0.
  - Inputs are ignored for that cycle.
- `mismatch` is sticky: once set, it clears only through rst.
- X or Z on any input: no defined requirement. The bench drives only 0/1.

## Timing
- `y_comb` follows inputs with combinational delay only (0 cycles).
- `y` (REG_OUT=1), `minterm` and `mismatch` have 1-cycle latency.
  - Inputs sampled at edge N appear on these outputs after edge N.
- Inputs changing every cycle: each edge captures the value present at that edge, with no skipped or merged samples.
- Reset asserted mid-stream:
  - Outputs are zero after the first edge with rst=1.
  - The first valid registered result appears one edge after rst deasserts.
- rst and an input change at the same edge: reset wins.
- Out of reset, before any active edge: register outputs are don't-care.

## Test plan
- Reset then idx sweep 0..15, one per cycle -> `y` one cycle later matches bits of 16'h44F4; `minterm` is one-hot with bit idx set; `mismatch` stays 0.
- Directed vectors, 10-cycle hold each:
  - 0000 -> 0
  - 0010 -> 1
  - 1101 -> 0
  - 1011 -> 0
  - 0110 -> 1
  - 1110 -> 1
  - `y_comb` must settle within the same cycle; `y` must follow one edge later.
- Reset mid-operation: drive 0110 (y=1), assert rst for 1 cycle -> y=0, minterm=0 after that edge; y returns to 1 one edge after rst drops.
- Override TT_INIT=16'h44F5 in an alternate instance, apply 0000 -> `mismatch` rises after one edge and remains 1 through later correct vectors until rst.
- REG_OUT=0 instance -> `y` equals `y_comb` at all times, including while rst=1.
- Back-to-back alternating 0010/0000 every cycle -> `y` toggles 1/0 each cycle, delayed by one cycle, with no missed samples.
